// File: rtl/fir_host_driver_if.sv
// fir_host_driver_if
// Groups every non-clock signal of the FIR host driver into one bundle.
//   coef_we/coef_addr/coef_wdata : fabric-side coefficient write port
//   c_address0/c_ce0/c_q0        : FIR coefficient read port
//   s_valid/s_data/s_ready       : input sample stream
//   ap_start/ap_done/ap_idle/ap_ready/ap_return/x : FIR block-level handshake
//   m_valid/m_data/m_ready       : result stream
//   timeout_err/result_count     : status
// Modports: master = the driver's view, slave = the surrounding system's view.
interface fir_host_driver_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4
);
  logic                 coef_we;
  logic [AddrWidth-1:0] coef_addr;
  logic [DataWidth-1:0] coef_wdata;
  logic [AddrWidth-1:0] c_address0;
  logic                 c_ce0;
  logic [DataWidth-1:0] c_q0;
  logic                 s_valid;
  logic [DataWidth-1:0] s_data;
  logic                 s_ready;
  logic                 ap_start;
  logic                 ap_done;
  logic                 ap_idle;
  logic                 ap_ready;
  logic [DataWidth-1:0] ap_return;
  logic [DataWidth-1:0] x;
  logic                 m_valid;
  logic [DataWidth-1:0] m_data;
  logic                 m_ready;
  logic                 timeout_err;
  logic [15:0]          result_count;

  modport master (
    input  coef_we, coef_addr, coef_wdata,
    input  c_address0, c_ce0,
    output c_q0,
    input  s_valid, s_data,
    output s_ready,
    output ap_start,
    input  ap_done, ap_idle, ap_ready, ap_return,
    output x,
    output m_valid, m_data,
    input  m_ready,
    output timeout_err, result_count
  );

  modport slave (
    output coef_we, coef_addr, coef_wdata,
    output c_address0, c_ce0,
    input  c_q0,
    output s_valid, s_data,
    input  s_ready,
    input  ap_start,
    output ap_done, ap_idle, ap_ready, ap_return,
    input  x,
    input  m_valid, m_data,
    output m_ready,
    input  timeout_err, result_count
  );
endinterface

// File: rtl/fir_host_driver.sv
// fir_host_driver
// Host-side companion of the fir accelerator. Owns the coefficient RAM that
// the FIR reads through c_address0/c_ce0/c_q0, takes one sample at a time from
// the input stream, launches a FIR run with a one-cycle ap_start pulse, waits
// (with a watchdog) for ap_done and hands ap_return out on the result stream.
// Ports:
//   ap_clk : clock, everything on the rising edge
//   ap_rst : asynchronous active-high reset
//   bus    : fir_host_driver_if master modport (RAM ports, streams, FIR
//            handshake, status)
module fir_host_driver #(
  parameter int DataWidth     = 32,
  parameter int NumTaps       = 11,
  parameter int AddrWidth     = 4,
  parameter int TimeoutCycles = 255
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  fir_host_driver_if.master  bus
);

  localparam int WdWidth = $clog2(TimeoutCycles + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    WAIT  = 4'b0100,
    OUT   = 4'b1000
  } state_t;

  state_t state;
  state_t state_next;

  logic [DataWidth-1:0] mem [NumTaps];
  logic [AddrWidth-1:0] wr_addr;
  logic [AddrWidth-1:0] rd_addr;
  logic                 wr_in_range;
  logic                 rd_in_range;

  logic [DataWidth-1:0] c_q0_r;
  logic [DataWidth-1:0] x_r;
  logic [DataWidth-1:0] m_data_r;
  logic                 ap_start_r;
  logic                 timeout_err_r;
  logic [15:0]          result_count_r;
  logic [WdWidth-1:0]   watchdog;

  logic accept;
  logic capture;
  logic expire;
  logic deliver;

  assign wr_addr     = bus.coef_addr;
  assign rd_addr     = bus.c_address0;
  assign wr_in_range = (32'(wr_addr) < NumTaps);
  assign rd_in_range = (32'(rd_addr) < NumTaps);

  assign bus.c_q0         = c_q0_r;
  assign bus.x            = x_r;
  assign bus.m_data       = m_data_r;
  assign bus.ap_start     = ap_start_r;
  assign bus.timeout_err  = timeout_err_r;
  assign bus.result_count = result_count_r;
  assign bus.s_ready      = (state == IDLE);
  assign bus.m_valid      = (state == OUT);

  // Coefficient storage has no reset; out-of-range writes are dropped.
  always_ff @(posedge ap_clk) begin
    if (bus.coef_we && wr_in_range) begin
      mem[wr_addr] <= bus.coef_wdata;
    end
  end

  // Registered read port. Nonblocking semantics give read-first behaviour
  // when the FIR reads the word that is being written in the same cycle.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      c_q0_r <= '0;
    end else if (bus.c_ce0) begin
      c_q0_r <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The watchdog holds the number of WAIT cycles already completed, so the
  // current WAIT cycle is number watchdog+1; the run is abandoned at the end
  // of WAIT cycle TimeoutCycles. A done in that same cycle still wins.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    deliver    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.s_valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.ap_done) begin
          capture    = 1'b1;
          state_next = OUT;
        end else if (watchdog == WdWidth'(TimeoutCycles - 1)) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ap_start is derived from the next state so the pulse comes straight off
  // a flop and lines up exactly with the START cycle.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ap_start_r     <= 1'b0;
      x_r            <= '0;
      m_data_r       <= '0;
      timeout_err_r  <= 1'b0;
      result_count_r <= '0;
      watchdog       <= '0;
    end else begin
      ap_start_r <= (state_next == START);
      if (accept) begin
        x_r <= bus.s_data;
      end
      if (state == START) begin
        watchdog <= '0;
      end else if (state == WAIT) begin
        watchdog <= watchdog + WdWidth'(1);
      end
      if (capture) begin
        m_data_r <= bus.ap_return;
      end
      if (expire) begin
        timeout_err_r <= 1'b1;
      end
      if (deliver) begin
        result_count_r <= result_count_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_host_driver.sv
// tb_fir_host_driver
// Self-checking bench for fir_host_driver. A behavioural FIR stub answers the
// ap_start handshake, reads the coefficients through the driver's read port
// and raises ap_done 56 cycles after the start cycle. Expected results come
// from an independent convolution over a sample history queue.
module tb_fir_host_driver;

  localparam int NumTaps = 11;

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        ce;
    logic [3:0]  raddr;
    logic [31:0] exp_q;
  } ram_vec_t;

  logic clk;
  logic rst;

  fir_host_driver_if #(.DataWidth(32), .AddrWidth(4)) bus ();

  fir_host_driver #(
    .DataWidth(32),
    .NumTaps(NumTaps),
    .AddrWidth(4),
    .TimeoutCycles(255)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus(bus.master)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] coef_model [NumTaps];
  logic [31:0] hist [$];
  logic [15:0] exp_count;

  logic        man_mode;
  logic        man_ce;
  logic [3:0]  man_addr;
  logic        stub_ce;
  logic [3:0]  stub_addr;
  logic        fir_dead;

  assign bus.c_ce0      = man_mode ? man_ce : stub_ce;
  assign bus.c_address0 = man_mode ? man_addr : stub_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang required completion");
    $fatal(1, "[TB] global timeout");
  end

  // FIR stub: shifts x into its own delay line on ap_start, fetches the 11
  // coefficients through the read port, reports the sum at start+56.
  initial begin
    logic        busy;
    int          n;
    logic [31:0] dl [NumTaps];
    logic [31:0] acc;
    busy = 1'b0;
    n = 0;
    acc = '0;
    for (int k = 0; k < NumTaps; k++) dl[k] = '0;
    bus.ap_done   = 1'b0;
    bus.ap_idle   = 1'b1;
    bus.ap_ready  = 1'b0;
    bus.ap_return = '0;
    stub_ce   = 1'b0;
    stub_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        for (int k = 0; k < NumTaps; k++) dl[k] = '0;
        bus.ap_done  = 1'b0;
        bus.ap_ready = 1'b0;
        bus.ap_idle  = 1'b1;
        stub_ce = 1'b0;
      end else if (!busy) begin
        bus.ap_done  = 1'b0;
        bus.ap_ready = 1'b0;
        if (bus.ap_start && !fir_dead) begin
          for (int k = NumTaps - 1; k > 0; k--) dl[k] = dl[k-1];
          dl[0] = bus.x;
          busy = 1'b1;
          n = 0;
          acc = '0;
          bus.ap_idle = 1'b0;
        end
      end else begin
        n++;
        if (n >= 2 && n <= NumTaps + 1) acc = acc + bus.c_q0 * dl[n-2];
        if (n <= NumTaps) begin
          stub_ce   = 1'b1;
          stub_addr = 4'(n - 1);
        end else begin
          stub_ce = 1'b0;
        end
        if (n == 56) begin
          bus.ap_done   = 1'b1;
          bus.ap_ready  = 1'b1;
          bus.ap_return = acc;
        end
        if (n == 57) begin
          bus.ap_done  = 1'b0;
          bus.ap_ready = 1'b0;
          bus.ap_idle  = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  task automatic golden_push(input logic [31:0] s, output logic [31:0] y);
    hist.push_front(s);
    if (hist.size() > NumTaps) void'(hist.pop_back());
    y = '0;
    foreach (hist[k]) y = y + coef_model[k] * hist[k];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    exp_count = '0;
    @(negedge clk);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [31:0] data);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = addr;
    bus.coef_wdata = data;
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (int'(addr) < NumTaps) coef_model[addr] = data;
  endtask

  // One RAM vector: drive for one cycle, check c_q0 after the edge.
  task automatic apply_stimulus(input ram_vec_t v, input int idx);
    bus.coef_we    = v.we;
    bus.coef_addr  = v.waddr;
    bus.coef_wdata = v.wdata;
    man_ce   = v.ce;
    man_addr = v.raddr;
    @(negedge clk);
    bus.coef_we = 1'b0;
    man_ce = 1'b0;
    if (v.we && int'(v.waddr) < NumTaps) coef_model[v.waddr] = v.wdata;
    check_output($sformatf("ram_vec_%0d", idx), bus.c_q0, v.exp_q);
  endtask

  // Full transaction: accept, start pulse, result latency, optional stall on
  // m_ready with a competing sample offered, then the result handshake.
  task automatic run_sample(input logic [31:0] sample, input int hold);
    logic [31:0] exp_y;
    int n;
    golden_push(sample, exp_y);
    check_output("idle_before_sample", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = sample;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_output("start_pulse_high", 32'(bus.ap_start), 32'd1);
    check_output("x_latched", bus.x, sample);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) check_output("start_pulse_low", 32'(bus.ap_start), 32'd0);
      if (bus.m_valid) break;
    end
    check_output("result_latency", 32'(n), 32'd57);
    check_output("result_data", bus.m_data, exp_y);
    for (int i = 0; i < hold; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = ~sample;
      @(negedge clk);
      check_output("hold_stable",
                   {bus.m_valid, bus.s_ready, bus.ap_start, 29'd0} ^ (bus.m_data ^ exp_y),
                   {3'b100, 29'd0});
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check_output("result_count", 32'(bus.result_count), 32'(exp_count));
    check_output("valid_dropped", 32'(bus.m_valid), 32'd0);
    check_output("x_held", bus.x, sample);
  endtask

  initial begin
    ram_vec_t vecs [12];
    logic     saw_valid;

    vecs[0]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd2,  32'h207};
    vecs[1]  = '{1'b1, 4'd12, 32'hDEAD, 1'b0, 4'd0,  32'h207};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd12, 32'h0};
    vecs[3]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd4,  32'h407};
    vecs[4]  = '{1'b1, 4'd2,  32'h5555, 1'b1, 4'd2,  32'h207};
    vecs[5]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd2,  32'h5555};
    vecs[6]  = '{1'b1, 4'd0,  32'h1234, 1'b0, 4'd0,  32'h5555};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd0,  32'h1234};
    vecs[8]  = '{1'b1, 4'd10, 32'h77,   1'b1, 4'd15, 32'h0};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd10, 32'h77};
    vecs[10] = '{1'b1, 4'd11, 32'hABCD, 1'b1, 4'd11, 32'h0};
    vecs[11] = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd3,  32'h307};

    rst = 1'b1;
    fir_dead = 1'b0;
    man_mode = 1'b1;
    man_ce = 1'b0;
    man_addr = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_wdata = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    for (int k = 0; k < NumTaps; k++) coef_model[k] = '0;
    exp_count = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check_output("rst_ap_start", 32'(bus.ap_start), 32'd0);
    check_output("rst_x", bus.x, 32'd0);
    check_output("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check_output("rst_m_data", bus.m_data, 32'd0);
    check_output("rst_c_q0", bus.c_q0, 32'd0);
    check_output("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check_output("rst_result_count", 32'(bus.result_count), 32'd0);

    $display("[TB] coefficient RAM vectors");
    for (int k = 0; k < NumTaps; k++) write_coef(4'(k), 32'h100 * k + 32'd7);
    for (int i = 0; i < 12; i++) apply_stimulus(vecs[i], i);
    man_mode = 1'b0;

    $display("[TB] single tap run");
    do_reset();
    write_coef(4'd0, 32'd3);
    for (int k = 1; k < NumTaps; k++) write_coef(4'(k), 32'd0);
    run_sample(32'd5, 0);

    $display("[TB] convolution 1,2,3 with stall");
    do_reset();
    for (int k = 0; k < NumTaps; k++) write_coef(4'(k), 32'(k + 1));
    run_sample(32'd1, 0);
    run_sample(32'd2, 20);
    run_sample(32'd3, 0);

    $display("[TB] watchdog timeout");
    fir_dead = 1'b1;
    check_output("idle_before_timeout", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd9;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_output("timeout_start", 32'(bus.ap_start), 32'd1);
    saw_valid = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      if (bus.m_valid) saw_valid = 1'b1;
      if (n == 255) begin
        check_output("timeout_not_yet", 32'(bus.timeout_err), 32'd0);
        check_output("still_waiting", 32'(bus.s_ready), 32'd0);
      end
    end
    check_output("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check_output("idle_after_timeout", 32'(bus.s_ready), 32'd1);
    check_output("no_result_on_timeout", 32'(saw_valid), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd11;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_output("accept_after_timeout", 32'(bus.ap_start), 32'd1);
    check_output("x_after_timeout", bus.x, 32'd11);
    check_output("timeout_sticky", 32'(bus.timeout_err), 32'd1);
    fir_dead = 1'b0;
    do_reset();
    check_output("timeout_cleared", 32'(bus.timeout_err), 32'd0);

    $display("[TB] reset during WAIT");
    run_sample(32'd4, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd6;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (20) @(negedge clk);
    check_output("in_wait", 32'(bus.s_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_output("async_s_ready", 32'(bus.s_ready), 32'd1);
    check_output("async_ap_start", 32'(bus.ap_start), 32'd0);
    check_output("async_m_valid", 32'(bus.m_valid), 32'd0);
    check_output("async_m_data", bus.m_data, 32'd0);
    check_output("async_x", bus.x, 32'd0);
    check_output("async_c_q0", bus.c_q0, 32'd0);
    check_output("async_result_count", 32'(bus.result_count), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    exp_count = '0;
    @(negedge clk);
    run_sample(32'd7, 0);

    $display("[TB] randomized runs");
    for (int k = 0; k < NumTaps; k++) begin
      if (k % 2 == 0) write_coef(4'(k), $urandom());
      else write_coef(4'(k), $urandom_range(0, 1000));
    end
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == 4) write_coef(4'($urandom_range(0, NumTaps - 1)), $urandom());
      run_sample($urandom(), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
